// File: rtl/soc_led_counter.sv
// LED bring-up top: a power-of-two clock divider issues a one-cycle tick
// that advances a free-running LED counter, plus an observable divided clock.
module soc_led_counter #(
    parameter int          DIV       = 20,
    parameter int          LED_WIDTH = 32,
    parameter int unsigned STEP      = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic                 DCLK
);

    // Tick fires on the count just before the MSB sets, so LEDS and DCLK move together.
    localparam logic [DIV-1:0]       TICK_VAL = DIV'((32'd1 << (DIV - 1)) - 32'd1);
    localparam logic [LED_WIDTH-1:0] STEP_VAL = LED_WIDTH'(STEP);

    logic [DIV-1:0]       divCnt_q;
    logic [DIV-1:0]       divCnt_d;
    logic                 dclk_q;
    logic                 dclk_d;
    logic [LED_WIDTH-1:0] leds_q;
    logic [LED_WIDTH-1:0] leds_d;
    logic                 tick;

    always_comb begin
        divCnt_d = divCnt_q + DIV'(1);
        dclk_d   = divCnt_d[DIV-1];
        tick     = (divCnt_q == TICK_VAL);
        leds_d   = leds_q;
        if (tick) begin
            leds_d = leds_q + STEP_VAL;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            divCnt_q <= '0;
            dclk_q   <= 1'b0;
            leds_q   <= '0;
        end else begin
            divCnt_q <= divCnt_d;
            dclk_q   <= dclk_d;
            leds_q   <= leds_d;
        end
    end

    assign LEDS = leds_q;
    assign DCLK = dclk_q;

endmodule

// File: tb/tb_soc_led_counter.sv
// Self-checking bench for soc_led_counter: four parameterisations share one
// clock and reset, checked against a closed-form edge-count model.
module tb_soc_led_counter;

    logic        clk;
    logic        resetN;
    logic [31:0] ledsD2;
    logic        dclkD2;
    logic [31:0] ledsD4;
    logic        dclkD4;
    logic [3:0]  ledsW4;
    logic        dclkW4;
    logic [31:0] ledsS3;
    logic        dclkS3;

    int testCount = 0;
    int failCount = 0;
    int edgeCount = 0;

    soc_led_counter #(.DIV(2), .LED_WIDTH(32), .STEP(1)) uDiv2 (
        .CLK(clk), .RESET(resetN), .LEDS(ledsD2), .DCLK(dclkD2));
    soc_led_counter #(.DIV(4), .LED_WIDTH(32), .STEP(1)) uDiv4 (
        .CLK(clk), .RESET(resetN), .LEDS(ledsD4), .DCLK(dclkD4));
    soc_led_counter #(.DIV(1), .LED_WIDTH(4), .STEP(1)) uWide4 (
        .CLK(clk), .RESET(resetN), .LEDS(ledsW4), .DCLK(dclkW4));
    soc_led_counter #(.DIV(3), .LED_WIDTH(32), .STEP(3)) uStep3 (
        .CLK(clk), .RESET(resetN), .LEDS(ledsS3), .DCLK(dclkS3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              inst;
        int              edgeNum;
        longint unsigned leds;
        bit              dclk;
    } vec_t;

    vec_t vecs[$];

    // Reference model: ticks land on edges h, h+P, h+2P, ... with h = P/2.
    function automatic int instDiv(int inst);
        case (inst)
            0:       return 2;
            1:       return 4;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int instStep(int inst);
        return (inst == 3) ? 3 : 1;
    endfunction

    function automatic int instWidth(int inst);
        return (inst == 2) ? 4 : 32;
    endfunction

    function automatic longint unsigned expLeds(int inst, int n);
        longint unsigned period = 64'd1 << instDiv(inst);
        longint unsigned half   = period / 2;
        longint unsigned ticks  = 0;
        if (longint'(n) >= longint'(half)) begin
            ticks = (longint'(n) - half) / period + 1;
        end
        return (ticks * instStep(inst)) & ((64'd1 << instWidth(inst)) - 1);
    endfunction

    function automatic bit expDclk(int inst, int n);
        longint unsigned period = 64'd1 << instDiv(inst);
        return (longint'(n) % period) >= (period / 2);
    endfunction

    function automatic longint unsigned actLeds(int inst);
        case (inst)
            0:       return 64'(ledsD2);
            1:       return 64'(ledsD4);
            2:       return 64'(ledsW4);
            default: return 64'(ledsS3);
        endcase
    endfunction

    function automatic bit actDclk(int inst);
        case (inst)
            0:       return dclkD2;
            1:       return dclkD4;
            2:       return dclkW4;
            default: return dclkS3;
        endcase
    endfunction

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    task automatic checkModel();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("model leds inst%0d", i), actLeds(i), expLeds(i, edgeCount));
            checkOutput($sformatf("model dclk inst%0d", i), 64'(actDclk(i)), 64'(expDclk(i, edgeCount)));
        end
    endtask

    task automatic checkZero(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s leds inst%0d", tag, i), actLeds(i), 64'd0);
            checkOutput($sformatf("%s dclk inst%0d", tag, i), 64'(actDclk(i)), 64'd0);
        end
    endtask

    // Drive reset at a falling edge so the next rising edge is edge 1 after release.
    task automatic applyStimulus(input logic resetVal);
        @(negedge clk);
        resetN = resetVal;
        if (!resetVal) edgeCount = 0;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        if (resetN) edgeCount++;
        @(negedge clk);
    endtask

    initial begin
        resetN = 1'b0;
        vecs.push_back('{0, 1, 0, 0});
        vecs.push_back('{0, 2, 1, 1});
        vecs.push_back('{0, 3, 1, 1});
        vecs.push_back('{0, 4, 1, 0});
        vecs.push_back('{0, 5, 1, 0});
        vecs.push_back('{0, 6, 2, 1});
        vecs.push_back('{0, 7, 2, 1});
        vecs.push_back('{0, 10, 3, 1});
        vecs.push_back('{1, 7, 0, 0});
        vecs.push_back('{1, 8, 1, 1});
        vecs.push_back('{1, 24, 2, 1});
        vecs.push_back('{1, 1000, 63, 1});
        vecs.push_back('{2, 1, 1, 1});
        vecs.push_back('{2, 2, 1, 0});
        vecs.push_back('{2, 29, 15, 1});
        vecs.push_back('{2, 31, 0, 1});
        vecs.push_back('{2, 33, 1, 1});
        vecs.push_back('{3, 3, 0, 0});
        vecs.push_back('{3, 4, 3, 1});
        vecs.push_back('{3, 12, 6, 1});
        vecs.push_back('{3, 20, 9, 1});

        #1;
        checkZero("power-on reset");
        for (int c = 0; c < 5; c++) begin
            stepEdge();
            checkZero("held reset");
        end

        applyStimulus(1'b1);
        for (int n = 1; n <= 1000; n++) begin
            stepEdge();
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].edgeNum == edgeCount) begin
                    checkOutput($sformatf("vec%0d leds", i), actLeds(vecs[i].inst), vecs[i].leds);
                    checkOutput($sformatf("vec%0d dclk", i), 64'(actDclk(vecs[i].inst)), 64'(vecs[i].dclk));
                end
            end
            checkModel();
        end

        // Asynchronous reset between edges while the DIV=2 counter reads 5.
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        while (edgeCount < 18) stepEdge();
        checkOutput("mid leds before reset", actLeds(0), 64'd5);
        #2 resetN = 1'b0;
        #1 checkZero("async reset");
        edgeCount = 0;
        stepEdge();
        checkZero("async reset hold");
        applyStimulus(1'b1);
        stepEdge();
        checkOutput("post-reset leds edge1", actLeds(0), 64'd0);
        stepEdge();
        checkOutput("post-reset leds edge2", actLeds(0), 64'd1);
        checkOutput("post-reset dclk edge2", 64'(actDclk(0)), 64'd1);

        // Randomised runs with randomly timed asynchronous resets.
        for (int r = 0; r < 25; r++) begin
            int runLen;
            runLen = int'($urandom_range(1, 150));
            for (int c = 0; c < runLen; c++) begin
                stepEdge();
                checkModel();
            end
            #($urandom_range(1, 4)) resetN = 1'b0;
            #1 checkZero("random async reset");
            edgeCount = 0;
            repeat ($urandom_range(0, 2)) stepEdge();
            applyStimulus(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
